// File: rtl/clock_divider_multi.sv
// Multi-channel phase-accumulator clock divider: per-channel square wave at a programmable rate in Hz.
// Optional macro CLKDIV_SYNC_EN adds a 'sync' input that restarts every channel in phase.
module clock_divider_multi #(
  parameter int unsigned BASE_SPEED = 50_000_000,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SPEED_W    = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en,
`ifdef CLKDIV_SYNC_EN
  input  logic                        sync,
`endif
  input  logic [CHANNELS*SPEED_W-1:0] speed,
  output logic [CHANNELS-1:0]         outClk,
  output logic [CHANNELS-1:0]         tick
);

  localparam int unsigned ACC_W = $clog2(2 * BASE_SPEED);
  // Arithmetic width wide enough for both 2*speed and acc+step without truncation.
  localparam int unsigned CW = ((SPEED_W + 1) > (ACC_W + 1)) ? (SPEED_W + 1) : (ACC_W + 1);
  localparam logic [CW-1:0] BASE_C = CW'(BASE_SPEED);

  logic clear_all;
`ifdef CLKDIV_SYNC_EN
  assign clear_all = sync;
`else
  assign clear_all = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_q, acc_d;
      logic             out_q, out_d;
      logic             tick_q, tick_d;
      logic [CW-1:0]    dbl, step, sum;

      always_comb begin
        dbl    = CW'(speed[gi*SPEED_W +: SPEED_W]) << 1;
        step   = (dbl > BASE_C) ? BASE_C : dbl;
        sum    = CW'(acc_q) + step;
        acc_d  = acc_q;
        out_d  = out_q;
        tick_d = 1'b0;
        if (!en[gi] || clear_all) begin
          acc_d = '0;
          out_d = 1'b0;
        end else if (sum >= BASE_C) begin
          acc_d  = ACC_W'(sum - BASE_C);
          out_d  = ~out_q;
          tick_d = ~out_q;
        end else begin
          acc_d = ACC_W'(sum);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          acc_q  <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          acc_q  <= acc_d;
          out_q  <= out_d;
          tick_q <= tick_d;
        end
      end

      assign outClk[gi] = out_q;
      assign tick[gi]   = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed tables, multi-cycle corner sequences and a randomized
// run against a total-phase reference model (toggle count = floor(total phase / BASE_SPEED)).
module tb_clock_divider_multi;

  localparam longint BASE0 = 50_000_000;
  localparam int     SW0   = 26;  // wide enough to express clamped speeds such as 30 MHz
  localparam int     SW1   = 8;

  logic             clk = 1'b0;
  logic             rst0 = 1'b0, rst1 = 1'b0;
  logic [3:0]       en0 = '0;
  logic [1:0]       en1 = '0;
  logic             sync0 = 1'b0;
  logic [4*SW0-1:0] speed0 = '0;
  logic [2*SW1-1:0] speed1 = '0;
  logic [3:0]       out0, tick0;
  logic [1:0]       out1, tick1;

  int checks = 0;
  int errors = 0;

  longint     ph [4];
  logic [3:0] m_out = '0, m_tick = '0;

  always #5 clk = ~clk;

  clock_divider_multi #(.BASE_SPEED(50_000_000), .CHANNELS(4), .SPEED_W(SW0)) u0 (
    .clk(clk), .rst(rst0), .en(en0),
`ifdef CLKDIV_SYNC_EN
    .sync(sync0),
`endif
    .speed(speed0), .outClk(out0), .tick(tick0));

  clock_divider_multi #(.BASE_SPEED(50), .CHANNELS(2), .SPEED_W(SW1)) u1 (
    .clk(clk), .rst(rst1), .en(en1),
`ifdef CLKDIV_SYNC_EN
    .sync(1'b0),
`endif
    .speed(speed1), .outClk(out1), .tick(tick1));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clk edge; the reference model for u0 advances on the same edge, then outputs settle.
  task automatic tick_clk();
    longint st, o, n;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      if (!rst0 || !en0[c] || sync0) begin
        ph[c] = 0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
      end else begin
        st = 2 * longint'(speed0[c*SW0 +: SW0]);
        if (st > BASE0) st = BASE0;
        o = ph[c] / BASE0;
        ph[c] += st;
        n = ph[c] / BASE0;
        m_out[c]  = n[0];
        m_tick[c] = (n != o) && n[0];
      end
    end
    #1;
  endtask

  task automatic set_spd0(input int ch, input longint v);
    speed0[ch*SW0 +: SW0] = SW0'(v);
  endtask

  task automatic reset0();
    rst0 = 1'b0;
    tick_clk();
    rst0 = 1'b1;
  endtask

  // Edges until out0[ch] equals lvl; -1 if the bound expires.
  task automatic wait_lvl(input int ch, input logic lvl, input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick_clk();
      if (out0[ch] == lvl) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct { longint spd; int exp_k; } rise_t;
  typedef struct { int s0, s1, tog0, tk0, mn0, mx0, tog1, tk1; } vec_t;

  rise_t rt[6];
  vec_t  vt[6];

  initial begin
    int k, k2;
    rt[0] = '{1_000_000, 25};
    rt[1] = '{3_000_000, 9};
    rt[2] = '{7_000_000, 4};
    rt[3] = '{25_000_000, 1};
    rt[4] = '{400_000, 63};
    rt[5] = '{30_000_000, 1};
    //         s0  s1 tog0 tk0 mn0 mx0 tog1 tk1
    vt[0] = '{ 3,  1,  6,   3,  8,  9,  2,   1};
    vt[1] = '{ 1,  3,  2,   1, 25, 25,  6,   3};
    vt[2] = '{ 7,  0, 14,   7,  3,  4,  0,   0};
    vt[3] = '{30,  5, 50,  25,  1,  1, 10,   5};
    vt[4] = '{ 5, 25, 10,   5,  5,  5, 50,  25};
    vt[5] = '{ 0,  7,  0,   0,  0,  0, 14,   7};

    // Reset state
    rst0 = 1'b0; rst1 = 1'b0; en0 = 4'hF; en1 = 2'b11;
    set_spd0(0, 1_000_000);
    tick_clk();
    chk("reset_out0", out0, 0);
    chk("reset_tick0", tick0, 0);
    chk("reset_out1", out1, 0);
    chk("reset_tick1", tick1, 0);
    $display("reset: out0=%b tick0=%b out1=%b tick1=%b", out0, tick0, out1, tick1);

    // First rising edge after reset release
    for (int i = 0; i < 6; i++) begin
      en0 = 4'b0001;
      set_spd0(0, rt[i].spd);
      reset0();
      wait_lvl(0, 1'b1, 300, k);
      $display("first_rise: speed=%0d edge=%0d expected=%0d", rt[i].spd, k, rt[i].exp_k);
      chk("first_rise", k, rt[i].exp_k);
      chk("first_rise_tick", tick0[0], 1);
    end

    // 1 MHz: rise 25, fall 50, rise 75, single-cycle ticks
    set_spd0(0, 1_000_000);
    reset0();
    wait_lvl(0, 1'b1, 100, k);
    chk("p1_rise", k, 25);
    tick_clk();
    chk("p1_tick_one_cycle", tick0[0], 0);
    wait_lvl(0, 1'b0, 100, k2);
    chk("p1_fall", k + 1 + k2, 50);
    wait_lvl(0, 1'b1, 100, k2);
    chk("p1_period_rise", k2, 25);
    chk("p1_tick2", tick0[0], 1);
    $display("p1: period check done at 1 MHz");

    // Small-base two-channel table, 50 clk window each
    for (int v = 0; v < 6; v++) begin
      int tog[2], tk[2], bad, lt0, mn, mx, hp;
      logic prev[2];
      logic cur;
      tog = '{0, 0}; tk = '{0, 0}; prev = '{1'b0, 1'b0};
      bad = 0; lt0 = 0; mn = 0; mx = 0;
      rst1 = 1'b0;
      tick_clk();
      rst1 = 1'b1; en1 = 2'b11;
      speed1 = {SW1'(vt[v].s1), SW1'(vt[v].s0)};
      for (int c = 1; c <= 50; c++) begin
        tick_clk();
        for (int ch = 0; ch < 2; ch++) begin
          cur = out1[ch];
          if (cur != prev[ch]) begin
            tog[ch]++;
            if (ch == 0) begin
              if (lt0 != 0) begin
                hp = c - lt0;
                if (mn == 0 || hp < mn) mn = hp;
                if (hp > mx) mx = hp;
              end
              lt0 = c;
            end
          end
          if (tick1[ch] != (cur && !prev[ch])) bad++;
          if (tick1[ch]) tk[ch]++;
          prev[ch] = cur;
        end
      end
      $display("vec%0d: s0=%0d s1=%0d tog0=%0d tk0=%0d hp0=[%0d,%0d] tog1=%0d tk1=%0d",
               v, vt[v].s0, vt[v].s1, tog[0], tk[0], mn, mx, tog[1], tk[1]);
      chk("vec_tog0", tog[0], vt[v].tog0);
      chk("vec_tick0", tk[0], vt[v].tk0);
      chk("vec_hpmin0", mn, vt[v].mn0);
      chk("vec_hpmax0", mx, vt[v].mx0);
      chk("vec_tog1", tog[1], vt[v].tog1);
      chk("vec_tick1", tk[1], vt[v].tk1);
      chk("vec_tick_rule", bad, 0);
    end

    // Clamp to clk/2, then speed 0 holds the high level
    en0 = 4'b0001;
    set_spd0(0, 30_000_000);
    reset0();
    for (int i = 1; i <= 6; i++) begin
      tick_clk();
      chk("clamp_out", out0[0], i % 2);
      chk("clamp_tick", tick0[0], i % 2);
    end
    tick_clk();
    set_spd0(0, 0);
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      chk("zero_hold_out", out0[0], 1);
      chk("zero_hold_tick", tick0[0], 0);
    end
    $display("clamp/zero: sequence done");

    // Enable drop for 3 clk, restart from zero on re-enable
    set_spd0(0, 1_000_000);
    reset0();
    repeat (30) tick_clk();
    chk("en_pre_high", out0[0], 1);
    en0[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      chk("en_low_out", out0[0], 0);
      chk("en_low_tick", tick0[0], 0);
    end
    en0[0] = 1'b1;
    wait_lvl(0, 1'b1, 100, k);
    chk("en_restart_rise", k, 25);
    $display("enable: restart rise after %0d clk", k);

`ifdef CLKDIV_SYNC_EN
    en0 = 4'b0011;
    set_spd0(0, 1_000_000);
    set_spd0(1, 500_000);
    reset0();
    repeat (37) tick_clk();
    sync0 = 1'b1;
    tick_clk();
    sync0 = 1'b0;
    chk("sync_out", out0[1:0], 0);
    chk("sync_tick", tick0[1:0], 0);
    k = -1; k2 = -1;
    for (int i = 1; i <= 60; i++) begin
      tick_clk();
      if (k < 0 && out0[0]) k = i;
      if (k2 < 0 && out0[1]) k2 = i;
    end
    chk("sync_rise0", k, 25);
    chk("sync_rise1", k2, 50);
    $display("sync: ch0 rise %0d ch1 rise %0d", k, k2);
`endif

    // Mid-period reset on all channels, then a reset glitch between edges
    en0 = 4'hF;
    for (int c = 0; c < 4; c++) set_spd0(c, 200_000 + 700_000 * c);
    reset0();
    repeat (37) tick_clk();
    rst0 = 1'b0;
    tick_clk();
    chk("midreset_out", out0, 0);
    chk("midreset_tick", tick0, 0);
    rst0 = 1'b1;
    repeat (40) tick_clk();
    #2 rst0 = 1'b0;
    #2 rst0 = 1'b1;
    tick_clk();
    chk("glitch_out", out0, m_out);
    chk("glitch_tick", tick0, m_tick);
    $display("reset: mid-period and glitch sequence done");

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) begin
        int ch, b;
        longint v;
        ch = $urandom_range(3);
        b  = $urandom_range(7);
        case (b)
          0: v = 0;
          1: v = longint'($urandom_range(30_000_000, 25_000_000));
          2: v = 24_999_999;
          3: v = 25_000_000;
          default: v = longint'($urandom_range(5_000_000, 1));
        endcase
        set_spd0(ch, v);
        $display("rand: cycle=%0d ch=%0d speed=%0d", i, ch, v);
      end
      for (int c = 0; c < 4; c++)
        if ($urandom_range(49) == 0) en0[c] = ~en0[c];
      tick_clk();
      chk("rand_out", out0, m_out);
      chk("rand_tick", tick0, m_tick);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel, parametrised successor to the single-output clock divider.
- Each channel generates a square wave at a runtime-programmable frequency in Hz from one system clock of known frequency BASE_SPEED.
- Uses a phase-accumulator (no hardware divider), so average frequency is exact for any integer speed, including speeds that do not divide BASE_SPEED evenly.
- Adds per-channel enable, a one-cycle rising-edge tick, and an output clamp at clk/2. Feeds LED blinkers, display scanners and game-tick logic.

Parameters:
- BASE_SPEED, 50_000_000: input clock frequency in Hz; accumulator wrap modulus.
- CHANNELS, 4: number of independent output channels (>= 1).
- SPEED_W, 20: width of each channel's speed field in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-low reset.
- en  input  CHANNELS  per-channel enable; bit i gates channel i.
- speed  input  CHANNELS*SPEED_W  packed requested frequencies in Hz; channel i is bits [i*SPEED_W +: SPEED_W].
- outClk  output  CHANNELS  per-channel divided square wave, registered.
- tick  output  CHANNELS  per-channel one-cycle pulse, high in the cycle outClk[i] becomes 1.

Behaviour:
- Reset: rst sampled low at a clk edge clears every accumulator, outClk and tick to 0 at that edge. Reset applied mid-operation has the same effect; no partial state survives.
- Accumulator width ACC_W = $clog2(2*BASE_SPEED). Invariant: acc < BASE_SPEED.
- Step per channel: step_i = min(2*speed_i, BASE_SPEED), computed at ACC_W+1 bits so nothing truncates.
- Per cycle, when en[i]=1 and rst=1:
  - sum = acc_i + step_i.
  - If sum >= BASE_SPEED: acc_i <= sum - BASE_SPEED and outClk[i] toggles.
  - Otherwise acc_i <= sum and outClk[i] holds.
- tick[i] is registered: it is 1 only in the cycle where outClk[i] transitions 0->1, and 0 otherwise.
- Resulting output frequency is speed_i Hz averaged over BASE_SPEED cycles. Half-periods differ by at most 1 clk when 2*speed does not divide BASE_SPEED.
- First edge: after reset release with constant speed s, outClk rises at clk edge k = ceil(BASE_SPEED/(2s)).
- Clamp: speed_i >= BASE_SPEED/2 gives step = BASE_SPEED, so outClk toggles every cycle (clk/2) and tick fires every 2 cycles.
- speed_i = 0: step = 0. acc and outClk hold their current values, no ticks.
- Speed change: the new value is used from the next edge. acc is preserved, so there is no glitch or restart; the current half-period completes at the new rate.
- en[i] low at an edge: acc_i, outClk[i] and tick[i] are cleared to 0. While en[i] stays low they remain 0. On re-enable, counting restarts from acc=0, exactly as after reset.
- Channels are fully independent. There is no shared state apart from clk and rst.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit, after en).
  - sync=1 at an edge clears all accumulators, outClk and tick to 0 on every channel, giving a phase-aligned restart.
  - rst has priority over sync. en=0 still forces a channel to 0.
- Undefined: no sync port and no related logic; behaviour is exactly as above.

Test Plan:
1. Defaults, ch0 speed=1_000_000, en=1, rst released at edge 0 -> outClk[0] rises at edge 25 and falls at edge 50; period 50 clk, duty 25/25; tick[0] high one cycle every 50 clk.
2. BASE_SPEED=50, ch0 speed=3, ch1 speed=1 concurrently -> over 50 clk, ch0 has 6 toggles / 3 ticks with half-periods in {8,9}; ch1 has 2 toggles / 1 tick, exact 25-cycle half-periods; neither channel affects the other.
3. Defaults, speed=30_000_000 (clamped) -> outClk toggles every clk, tick every 2 clk; speed=0 mid-high -> outClk held at 1 with no further ticks.
4. ch0 running at 1_000_000, en[0] dropped for 3 clk then raised -> outClk[0]=0 and tick[0]=0 from the first low edge; after re-enable, first rise 25 clk later.
5. rst driven low for 1 edge mid-period on all channels -> all outClk and tick are 0 at that edge; rst is sampled only at edges, so an async glitch between edges has no effect.
6. CLKDIV_SYNC_EN defined, ch0=1_000_000 and ch1=500_000 out of phase, sync pulsed -> both clear to 0; ch0 rises 25 clk later and ch1 rises 50 clk later, aligned from the sync edge.
